// File: rtl/cond_issue_ctrl.sv
// rtl/cond_issue_ctrl.sv - ID->EX issue/condition controller owning CPSR NZCV
// Optional build macro: FLAG_FWD_EN (forward ALU flags to issue instead of stalling).
module cond_issue_ctrl #(
    parameter int         CNT_W     = 16,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_cond,
    input  logic             id_s,
    output logic             id_ready,
    input  logic             ex_ready,
    input  logic [3:0]       alu_flags,
    input  logic             flush,
    output logic             ex_valid,
    output logic             ex_exec,
    output logic             ex_s,
    output logic [3:0]       status,
    output logic [CNT_W-1:0] stall_cnt
);

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = ~c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = c & ~z;
            4'b1001: cond_eval = ~c | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            4'b1110: cond_eval = 1'b1;
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic       slot_free;
    logic       retire;
    logic       flag_setter;
    logic       hazard;
    logic       issue;
    logic [3:0] eval_flags;

    always_comb begin
        slot_free   = ~ex_valid | ex_ready;
        retire      = ex_valid & ex_ready & ~flush;
        flag_setter = ex_valid & ex_exec & ex_s;
`ifdef FLAG_FWD_EN
        hazard      = 1'b0;
        // Flags the EX instruction writes this edge are visible to the one issuing now.
        eval_flags  = (flag_setter & ex_ready) ? alu_flags : status;
`else
        hazard      = id_valid & flag_setter & (id_cond != 4'b1110);
        eval_flags  = status;
`endif
        id_ready    = ~rst & ~flush & slot_free & ~hazard;
        issue       = id_valid & id_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_exec   <= 1'b0;
            ex_s      <= 1'b0;
            status    <= RST_FLAGS;
            stall_cnt <= '0;
        end else begin
            if (issue) begin
                ex_valid <= 1'b1;
                ex_s     <= id_s;
                ex_exec  <= cond_eval(id_cond, eval_flags);
            end else if (retire | flush) begin
                ex_valid <= 1'b0;
                ex_exec  <= 1'b0;
                ex_s     <= 1'b0;
            end

            if (retire & ex_exec & ex_s)
                status <= alu_flags;

            if (hazard & ~flush & ~(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// tb/tb_cond_issue_ctrl.sv - vector table, corner sequences and random model check for cond_issue_ctrl
module tb_cond_issue_ctrl;

    localparam int CNT_W = 4;
`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [3:0]       id_cond;
    logic             id_s;
    logic             id_ready;
    logic             ex_ready;
    logic [3:0]       alu_flags;
    logic             flush;
    logic             ex_valid;
    logic             ex_exec;
    logic             ex_s;
    logic [3:0]       status;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    cond_issue_ctrl #(.CNT_W(CNT_W), .RST_FLAGS(4'b0000)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
        .id_ready(id_ready), .ex_ready(ex_ready), .alu_flags(alu_flags), .flush(flush),
        .ex_valid(ex_valid), .ex_exec(ex_exec), .ex_s(ex_s), .status(status),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] cond;
        logic       s;
        logic       rdy;
        logic [3:0] alu;
        logic       fl;
        logic       e_rdy;
        logic       e_ev;
        logic       e_ex;
        logic       e_s;
        logic [3:0] e_st;
        logic [3:0] e_cnt;
    } vec_t;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] cond, input logic s,
                         input logic rdy, input logic [3:0] alu, input logic fl);
        id_valid = v; id_cond = cond; id_s = s; ex_ready = rdy; alu_flags = alu; flush = fl;
    endtask

    // Standard ARM encoding: pairs share a base test, odd codes invert it.
    function automatic logic ref_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return cond[0] ? !base : base;
    endfunction

    // Reference state
    bit       m_valid, m_exec, m_s;
    bit [3:0] m_status;
    int       m_cnt;

    vec_t vecs[12];

    initial begin
        automatic logic       C = FWD ? 1'b0 : 1'b1;
        automatic logic [3:0] cnt_exp;
        rst = 1'b1;
        drive(0, 4'h0, 0, 0, 4'h0, 0);
        @(posedge clk); #1;
        chk("ready_in_rst", id_ready, 0);
        @(posedge clk); #1;
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_ex_exec", ex_exec, 0);
        chk("rst_ex_s", ex_s, 0);
        chk("rst_status", status, 0);
        chk("rst_cnt", stall_cnt, 0);
        rst = 1'b0;

        //            v cond  s rdy alu   fl  rdy  ev   ex   s  st    cnt
        vecs[0]  = '{1, 4'h0, 0, 1, 4'h0, 0,  1,   1,   0,   0, 4'h0, 4'h0};
        vecs[1]  = '{1, 4'hE, 1, 1, 4'h0, 0,  1,   1,   1,   1, 4'h0, 4'h0};
        vecs[2]  = '{1, 4'h0, 0, 1, 4'h4, 0,  FWD, FWD, FWD, 0, 4'h4, {3'b0, C}};
        vecs[3]  = '{1, 4'h0, 0, 1, 4'h0, 0,  1,   1,   1,   0, 4'h4, {3'b0, C}};
        vecs[4]  = '{1, 4'hE, 0, 0, 4'hF, 0,  0,   1,   1,   0, 4'h4, {3'b0, C}};
        vecs[5]  = '{1, 4'hE, 0, 0, 4'hF, 0,  0,   1,   1,   0, 4'h4, {3'b0, C}};
        vecs[6]  = '{1, 4'hE, 0, 0, 4'hF, 0,  0,   1,   1,   0, 4'h4, {3'b0, C}};
        vecs[7]  = '{1, 4'hE, 1, 1, 4'h0, 0,  1,   1,   1,   1, 4'h4, {3'b0, C}};
        vecs[8]  = '{1, 4'hE, 0, 1, 4'h8, 1,  0,   0,   0,   0, 4'h4, {3'b0, C}};
        vecs[9]  = '{1, 4'hF, 1, 1, 4'h0, 0,  1,   1,   0,   1, 4'h4, {3'b0, C}};
        vecs[10] = '{1, 4'hE, 0, 1, 4'hF, 0,  1,   1,   1,   0, 4'h4, {3'b0, C}};
        vecs[11] = '{1, 4'hE, 1, 1, 4'h0, 0,  1,   1,   1,   1, 4'h4, {3'b0, C}};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].cond, vecs[i].s, vecs[i].rdy, vecs[i].alu, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d_id_ready", i), id_ready, vecs[i].e_rdy);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ex_valid", i), ex_valid, vecs[i].e_ev);
            chk($sformatf("vec%0d_ex_exec", i), ex_exec, vecs[i].e_ex);
            if (vecs[i].e_ev)
                chk($sformatf("vec%0d_ex_s", i), ex_s, vecs[i].e_s);
            chk($sformatf("vec%0d_status", i), status, vecs[i].e_st);
            chk($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].e_cnt);
        end

        // Flag-setter held in EX under backpressure while EQ waits: counter saturates.
        for (int k = 1; k <= 20; k++) begin
            drive(1, 4'h0, 0, 0, 4'h0, 0);
            #1;
            chk("sat_id_ready", id_ready, 0);
            @(posedge clk); #1;
            cnt_exp = FWD ? 4'(C) : ((C + k) > 15 ? 4'hF : 4'(C + k));
            chk("sat_cnt", stall_cnt, cnt_exp);
            chk("sat_ex_valid", ex_valid, 1);
            chk("sat_status", status, 4'h4);
        end
        drive(1, 4'h0, 0, 1, 4'h2, 0);
        #1;
        chk("rel_id_ready", id_ready, FWD);
        @(posedge clk); #1;
        chk("rel_status", status, 4'h2);
        chk("rel_cnt", stall_cnt, FWD ? 4'(C) : 4'hF);
        chk("rel_ex_valid", ex_valid, FWD);
        drive(1, 4'h0, 0, 1, 4'h0, 0);
        #1;
        chk("post_id_ready", id_ready, 1);
        @(posedge clk); #1;
        chk("post_ex_valid", ex_valid, 1);
        chk("post_ex_exec", ex_exec, 0);

        // Randomised run against the reference model.
        rst = 1'b1;
        drive(0, 4'h0, 0, 0, 4'h0, 0);
        @(posedge clk); #1;
        m_valid = 0; m_exec = 0; m_s = 0; m_status = 4'h0; m_cnt = 0;
        for (int n = 0; n < 4000; n++) begin
            bit       r_rst, v, s, rdy, fl, busy, hz, take, exp_rdy, fire, ret;
            bit [3:0] cond, alu, f;
            r_rst = ($urandom_range(99) == 0);
            v     = ($urandom_range(3) != 0);
            cond  = ($urandom_range(3) == 0) ? 4'hE : 4'($urandom_range(15));
            s     = $urandom_range(1);
            rdy   = ($urandom_range(3) != 0);
            fl    = ($urandom_range(15) == 0);
            alu   = 4'($urandom_range(15));
            rst   = r_rst;
            drive(v, cond, s, rdy, alu, fl);

            busy    = m_valid && m_exec && m_s;
            hz      = !FWD && v && busy && cond != 4'hE;
            take    = !m_valid || rdy;
            exp_rdy = !r_rst && !fl && take && !hz;
            fire    = v && exp_rdy;
            ret     = m_valid && rdy && !fl;
            f       = (FWD && busy && rdy) ? alu : m_status;
            #1;
            chk("rnd_id_ready", id_ready, exp_rdy);

            if (r_rst) begin
                m_valid = 0; m_exec = 0; m_s = 0; m_status = 4'h0; m_cnt = 0;
            end else begin
                if (ret && m_exec && m_s) m_status = alu;
                if (hz && !fl && m_cnt < 15) m_cnt++;
                if (fire) begin
                    m_valid = 1; m_s = s; m_exec = ref_pass(cond, f);
                end else if (ret || fl) begin
                    m_valid = 0; m_exec = 0;
                end
            end
            @(posedge clk); #1;
            chk("rnd_ex_valid", ex_valid, m_valid);
            chk("rnd_ex_exec", ex_exec, m_exec);
            if (m_valid) chk("rnd_ex_s", ex_s, m_s);
            chk("rnd_status", status, m_status);
            chk("rnd_cnt", stall_cnt, 16'(m_cnt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
